// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared word width, size encodings and FSM states for the memory access unit
package mem_access_pkg;
  localparam int WORD_W = 32;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, RD, WR, WR_REL, RESP} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane merge for sub-word stores and lane extract/extend for loads
//  word   in  memory word (old word for merge, read word for extract)
//  wdata  in  right-aligned store data
//  size   in  SZ_* access size
//  lane   in  byte address bits [1:0]
//  sgn    in  sign-extend loads
//  merged out word with only the addressed lane(s) replaced
//  loaded out extracted and extended load data
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              sgn,
  output logic [WORD_W-1:0] merged,
  output logic [WORD_W-1:0] loaded
);
  logic [4:0]        sh;
  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] s;
  always_comb begin
    sh     = size == SZ_BYTE ? {lane, 3'b000} : size == SZ_HALF ? {lane[1], 4'b0000} : 5'd0;
    mask   = (size == SZ_BYTE ? 32'h0000_00ff : size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff) << sh;
    merged = (word & ~mask) | ((wdata << sh) & mask);
    s      = word >> sh;
    loaded = size == SZ_BYTE ? {{24{sgn & s[7]}}, s[7:0]} :
             size == SZ_HALF ? {{16{sgn & s[15]}}, s[15:0]} : word;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store requests to word-addressed memory, RMW for sub-word stores
//  req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata  request handshake and fields
//  resp_valid/resp_rdata/resp_err                                      one-cycle completion
//  mem_addr/mem_we/mem_wdata/mem_rdata                                 word memory port
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);
  localparam int CW = READ_LAT > 1 ? $clog2(READ_LAT) : 1;
  localparam logic [31:0] AMASK = (32'd1 << DEPTH_LOG2) - 32'd1;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic              we_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [1:0]        lane_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] merged;
  logic [WORD_W-1:0] loaded;
  logic              bad;
  assign bad = (req_size == SZ_HALF && req_addr[0]) || (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
               req_size == 2'b11 || (req_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
  mem_lane_align u_align (
    .word   (mem_rdata),
    .wdata  (wdata_q),
    .size   (size_q),
    .lane   (lane_q),
    .sgn    (sgn_q),
    .merged (merged),
    .loaded (loaded)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      sgn_q      <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we_q      <= req_we;
          size_q    <= req_size;
          sgn_q     <= req_signed;
          lane_q    <= req_addr[1:0];
          wdata_q   <= req_wdata;
          cnt       <= '0;
          req_ready <= 1'b0;
          if (bad) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            mem_addr  <= (req_addr >> 2) & AMASK;
            mem_wdata <= req_wdata;
            state     <= req_we && req_size == SZ_WORD ? WR : RD;
          end
        end
        RD: if (cnt == CW'(READ_LAT - 1)) begin
          if (we_q) begin
            mem_wdata <= merged;
            state     <= WR;
          end else begin
            resp_rdata <= loaded;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end else cnt <= cnt + 1'b1;
        WR: begin
          mem_we <= 1'b1;
          state  <= WR_REL;
        end
        WR_REL: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed scoreboard bench, instance 0 with READ_LAT=1, instance 1 with READ_LAT=3
module tb_mem_access_unit;
  typedef struct { logic [31:0] rd; logic err; int lat; } exp_t;
  logic        clk;
  logic        reset_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [1:0]  req_size [2];
  logic        req_signed [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err [2];
  logic [31:0] mem_addr [2];
  logic        mem_we [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] mem [2][4096];
  exp_t        sb0 [$];
  exp_t        sb1 [$];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          acc [2];
  bit          busy [2];
  int          we_cnt [2];
  logic [31:0] we_addr [2];
  logic [31:0] prev_addr [2];
  logic [31:0] prev_wdata [2];
  mem_access_unit #(.DEPTH_LOG2(12), .READ_LAT(1)) u0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .mem_addr(mem_addr[0]),
    .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );
  mem_access_unit #(.DEPTH_LOG2(12), .READ_LAT(3)) u1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .mem_addr(mem_addr[1]),
    .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );
  assign mem_rdata[0] = mem[0][mem_addr[0][11:0]];
  assign mem_rdata[1] = mem[1][mem_addr[1][11:0]];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (mem_we[i]) mem[i][mem_addr[i][11:0]] <= mem_wdata[i];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic int qsize(input int d);
    return d == 0 ? sb0.size() : sb1.size();
  endfunction
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) busy[i] = 1'b0;
      if (resp_valid[i]) begin
        chk("ready_in_resp", req_ready[i], 0);
        if (qsize(i) == 0) chk("unexpected_resp", 1, 0);
        else begin
          if (i == 0) e = sb0.pop_front();
          else e = sb1.pop_front();
          chk("resp_rdata", resp_rdata[i], e.rd);
          chk("resp_err", resp_err[i], e.err);
          chk("latency", cyc - acc[i], e.lat);
        end
        busy[i] = 1'b0;
      end else if (busy[i]) chk("ready_busy", req_ready[i], 0);
      if (req_valid[i] && req_ready[i]) begin
        acc[i]  = cyc;
        busy[i] = 1'b1;
      end
      if (mem_we[i]) begin
        we_cnt[i]++;
        we_addr[i] = mem_addr[i];
        chk("we_addr_stable", mem_addr[i], prev_addr[i]);
        chk("we_wdata_stable", mem_wdata[i], prev_wdata[i]);
      end
      prev_addr[i]  = mem_addr[i];
      prev_wdata[i] = mem_wdata[i];
    end
  end
  task automatic drive(input int d, input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd);
    req_we[d]     = we;
    req_size[d]   = sz;
    req_signed[d] = sg;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    req_valid[d]  = 1'b1;
  endtask
  task automatic wait_accept(input int d);
    int k = 0;
    @(negedge clk);
    while (!req_ready[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept_timeout", req_ready[d], 1);
  endtask
  task automatic wait_drain(input int d);
    int k = 0;
    while (qsize(d) != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("resp_timeout", qsize(d), 0);
  endtask
  task automatic issue(input int d, input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic er, input int lat);
    exp_t e = '{rd, er, lat};
    if (d == 0) sb0.push_back(e);
    else sb1.push_back(e);
    @(posedge clk);
    #1 drive(d, we, sz, sg, a, wd);
    wait_accept(d);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    wait_drain(d);
  endtask
  task automatic chk_idle(input int d);
    chk("rst_req_ready", req_ready[d], 1);
    chk("rst_resp_valid", resp_valid[d], 0);
    chk("rst_resp_rdata", resp_rdata[d], 0);
    chk("rst_resp_err", resp_err[d], 0);
    chk("rst_mem_we", mem_we[d], 0);
    chk("rst_mem_addr", mem_addr[d], 0);
    chk("rst_mem_wdata", mem_wdata[d], 0);
  endtask
  initial begin
    int w0;
    logic [31:0] a0;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      drive(i, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      req_valid[i] = 1'b0;
      we_cnt[i] = 0;
      busy[i] = 1'b0;
      acc[i] = 0;
      for (int j = 0; j < 4096; j++) mem[i][j] = 32'h0;
    end
    mem[0][12] = 32'h5566_7788;
    mem[1][16] = 32'h1234_5678;
    mem[1][17] = 32'hCAFE_0000;
    repeat (3) @(posedge clk);
    #1 chk_idle(0);
    chk_idle(1);
    reset_n = 1'b1;
    // reset during the read phase of a byte store
    @(posedge clk);
    #1 drive(0, 1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_00EE);
    @(negedge clk);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("rmw_mid_rd_addr", mem_addr[0], 12);
    #2 reset_n = 1'b0;
    #1 chk_idle(0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_mem_unchanged", mem[0][12], 32'h5566_7788);
    chk("rst_no_write", we_cnt[0], 0);
    @(negedge clk);
    chk("rst_ready_after", req_ready[0], 1);
    // word store then word load
    issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
    chk("word_store_we_cnt", we_cnt[0], 1);
    chk("word_store_addr", we_addr[0], 4);
    chk("word_store_mem", mem[0][4], 32'hDEAD_BEEF);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
    // byte RMW store and loads
    issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 3);
    issue(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h7777_77A5, 32'h0, 1'b0, 4);
    chk("byte_store_mem", mem[0][4], 32'hA522_3344);
    issue(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFF_FFA5, 1'b0, 2);
    issue(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0000_00A5, 1'b0, 2);
    issue(0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h0000_0044, 1'b0, 2);
    // half RMW store and loads
    issue(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 3);
    issue(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_8001, 32'h0, 1'b0, 4);
    chk("half_store_mem", mem[0][8], 32'h8001_0000);
    issue(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0, 2);
    issue(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_8001, 1'b0, 2);
    // errors: no memory cycle, address held
    w0 = we_cnt[0];
    a0 = mem_addr[0];
    issue(0, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1);
    issue(0, 1'b0, 2'b01, 1'b1, 32'h1, 32'h0, 32'h0, 1'b1, 1);
    issue(0, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    issue(0, 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1, 1);
    issue(0, 1'b1, 2'b10, 1'b0, 32'h4000, 32'h1234_5678, 32'h0, 1'b1, 1);
    chk("err_no_we", we_cnt[0], w0);
    chk("err_addr_held", mem_addr[0], a0);
    // READ_LAT=3, three loads queued with req_valid held high
    sb1.push_back('{32'h1234_5678, 1'b0, 4});
    sb1.push_back('{32'h0000_0056, 1'b0, 4});
    sb1.push_back('{32'hFFFF_CAFE, 1'b0, 4});
    @(posedge clk);
    #1 drive(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    wait_accept(1);
    @(posedge clk);
    #1 drive(1, 1'b0, 2'b00, 1'b0, 32'h41, 32'h0);
    wait_accept(1);
    @(posedge clk);
    #1 drive(1, 1'b0, 2'b01, 1'b1, 32'h46, 32'h0);
    wait_accept(1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_drain(1);
    chk("lat3_no_we", we_cnt[1], 0);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
